// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    // Register 0 is hardwired zero: never stored, marked busy or dumped.
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [0:0] {
        DBG_IDLE,
        DBG_BEAT
    } dbg_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register with flush > set > clear priority,
// plus NRD combinational lookup ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_sel,
    input  logic              sb_flush,
    input  logic              w_en,
    input  logic [AW-1:0]     w_sel,
    input  logic [NRD*AW-1:0] lk_sel,
    output logic [NRD-1:0]    lk_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (w_en) begin
            busy_d[w_sel] = 1'b0;
        end
        // Applied after the clear so an issue racing its own writeback stays pending.
        if (sb_set) begin
            busy_d[sb_sel] = 1'b1;
        end
        if (sb_flush) begin
            busy_d = '0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_lookup
        assign lk_busy[k] = busy_q[lk_sel[k*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard and handshaked debug dump.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   r_sel,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]      r_busy,
    input  logic                w_en,
    input  logic [AW-1:0]       w_sel,
    input  logic [XLEN-1:0]     w_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_sel,
    input  logic                sb_flush,
    input  logic                dbg_req,
    output logic                dbg_valid,
    input  logic                dbg_ready,
    output logic [AW-1:0]       dbg_idx,
    output logic [XLEN-1:0]     dbg_data,
    output logic                dbg_active
);

    localparam logic [AW-1:0] ZERO_IDX  = AW'(REG_ZERO);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    logic            wr_hit;
    logic [NRD-1:0]  lk_busy;

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    dbg_state_e      state_q;
    dbg_state_e      state_d;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_d;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;

    assign wr_hit = w_en && (w_sel != ZERO_IDX);

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[w_sel] = w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .sb_set   (sb_set),
        .sb_sel   (sb_sel),
        .sb_flush (sb_flush),
        .w_en     (w_en),
        .w_sel    (w_sel),
        .lk_sel   (r_sel),
        .lk_busy  (lk_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0]   sel;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign sel = r_sel[k*AW +: AW];

        always_comb begin
            rd = (sel == ZERO_IDX) ? '0 : mem_q[sel];
            rb = lk_busy[k];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; busy reflects what the edge will leave behind.
            if (wr_hit && (sel == w_sel)) begin
                rd = w_data;
                rb = sb_set && !sb_flush && (sb_sel == w_sel);
            end
`endif
        end

        assign r_data[k*XLEN +: XLEN] = rd;
        assign r_busy[k]              = rb;
    end

    // Beat capture reads mem_d so a write on the same edge is what gets dumped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    state_d = DBG_BEAT;
                    idx_d   = FIRST_IDX;
                    data_d  = mem_d[FIRST_IDX];
                end
            end
            DBG_BEAT: begin
                if (dbg_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DBG_IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = mem_d[idx_q + 1'b1];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DBG_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign dbg_valid  = (state_q == DBG_BEAT);
    assign dbg_active = (state_q == DBG_BEAT);
    assign dbg_idx    = idx_q;
    assign dbg_data   = data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reads, writes, scoreboard, dump with backpressure, reset abort.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    typedef struct packed {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   r_sel;
    logic [NRD*XLEN-1:0] r_data;
    logic [NRD-1:0]      r_busy;
    logic                w_en;
    logic [AW-1:0]       w_sel;
    logic [XLEN-1:0]     w_data;
    logic                sb_set;
    logic [AW-1:0]       sb_sel;
    logic                sb_flush;
    logic                dbg_req;
    logic                dbg_valid;
    logic                dbg_ready;
    logic [AW-1:0]       dbg_idx;
    logic [XLEN-1:0]     dbg_data;
    logic                dbg_active;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .r_sel      (r_sel),
        .r_data     (r_data),
        .r_busy     (r_busy),
        .w_en       (w_en),
        .w_sel      (w_sel),
        .w_data     (w_data),
        .sb_set     (sb_set),
        .sb_sel     (sb_sel),
        .sb_flush   (sb_flush),
        .dbg_req    (dbg_req),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_idx    (dbg_idx),
        .dbg_data   (dbg_data),
        .dbg_active (dbg_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    hs;
        int    cyc;
        int    phase;
        beat_t b;

        rst = 1'b1;
        r_sel = '0; w_en = 1'b0; w_sel = '0; w_data = '0;
        sb_set = 1'b0; sb_sel = '0; sb_flush = 1'b0;
        dbg_req = 1'b0; dbg_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        r_sel = {5'd31, 5'd5};
        #1;
        check("rst_rd_x5", 64'(r_data[31:0]), 64'h0);
        check("rst_rd_x31", 64'(r_data[63:32]), 64'h0);
        check("rst_busy", 64'(r_busy), 64'h0);
        check("rst_dbg_valid", 64'(dbg_valid), 64'h0);
        check("rst_dbg_active", 64'(dbg_active), 64'h0);
        check("rst_dbg_idx", 64'(dbg_idx), 64'h0);
        check("rst_dbg_data", 64'(dbg_data), 64'h0);

        // Write x7 and read it in the same cycle, then the next
        tick();
        w_en = 1'b1; w_sel = 5'd7; w_data = 32'hDEADBEEF; r_sel = {5'd0, 5'd7};
        @(negedge clk);
        check("wr_same_cycle_x7", 64'(r_data[31:0]), BYP ? 64'hDEADBEEF : 64'h0);
        tick();
        w_en = 1'b0;
        @(negedge clk);
        check("wr_next_cycle_x7", 64'(r_data[31:0]), 64'hDEADBEEF);

        // Write to x0 is discarded
        tick();
        w_en = 1'b1; w_sel = 5'd0; w_data = 32'h1234; r_sel = {5'd7, 5'd0};
        @(negedge clk);
        check("wr_x0_same", 64'(r_data[31:0]), 64'h0);
        tick();
        w_en = 1'b0;
        @(negedge clk);
        check("wr_x0_after", 64'(r_data[31:0]), 64'h0);
        check("rd_port1_x7", 64'(r_data[63:32]), 64'hDEADBEEF);
        check("busy_x0", 64'(r_busy[0]), 64'h0);

        // Scoreboard
        tick();
        sb_set = 1'b1; sb_sel = 5'd3; r_sel = {5'd4, 5'd3};
        @(negedge clk);
        check("sb_x3_before", 64'(r_busy[0]), 64'h0);
        tick();
        sb_set = 1'b0;
        @(negedge clk);
        check("sb_x3_set", 64'(r_busy[0]), 64'h1);
        tick();
        sb_set = 1'b1; sb_sel = 5'd3; w_en = 1'b1; w_sel = 5'd3; w_data = 32'h33;
        @(negedge clk);
        check("sb_x3_race_same", 64'(r_busy[0]), 64'h1);
        tick();
        sb_set = 1'b0; w_en = 1'b0;
        @(negedge clk);
        check("sb_x3_race_after", 64'(r_busy[0]), 64'h1);
        check("sb_x3_race_data", 64'(r_data[31:0]), 64'h33);
        tick();
        w_en = 1'b1; w_sel = 5'd3; w_data = 32'h34;
        @(negedge clk);
        check("sb_x3_clr_same", 64'(r_busy[0]), BYP ? 64'h0 : 64'h1);
        tick();
        w_en = 1'b0;
        @(negedge clk);
        check("sb_x3_clr_after", 64'(r_busy[0]), 64'h0);
        tick();
        sb_set = 1'b1; sb_sel = 5'd4; sb_flush = 1'b1;
        tick();
        sb_set = 1'b0; sb_flush = 1'b0;
        @(negedge clk);
        check("sb_x4_flush", 64'(r_busy[1]), 64'h0);
        tick();
        sb_set = 1'b1; sb_sel = 5'd0;
        tick();
        sb_set = 1'b0; r_sel = {5'd4, 5'd0};
        @(negedge clk);
        check("sb_x0_never_busy", 64'(r_busy[0]), 64'h0);

        // Preload xi = i*0x11
        for (int i = 1; i < NREGS; i++) begin
            tick();
            w_en = 1'b1; w_sel = AW'(i); w_data = XLEN'(i * 32'h11);
        end
        tick();
        w_en = 1'b0;

        // Dump with random backpressure
        dbg_req = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            exp_q.push_back('{idx: AW'(i), data: XLEN'(i * 32'h11)});
        end
        tick();
        dbg_req = 1'b0;
        hs = 0; cyc = 0; phase = 0;
        while (hs < NREGS - 1 && cyc < 600) begin
            w_en = 1'b0;
            if (dbg_valid && dbg_idx == 5'd5 && phase == 0) begin
                dbg_ready = 1'b0;
                w_en = 1'b1; w_sel = 5'd5; w_data = 32'hAA;
                phase = 1;
            end else if (dbg_valid && dbg_idx == 5'd5 && phase == 1) begin
                // x6 rewritten on the same edge that captures it
                dbg_ready = 1'b1;
                w_en = 1'b1; w_sel = 5'd6; w_data = 32'hBB;
                if (exp_q.size() > 1) begin
                    b = exp_q[1];
                    b.data = 32'hBB;
                    exp_q[1] = b;
                end
                phase = 2;
            end else begin
                dbg_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("dump_valid", 64'(dbg_valid), 64'h1);
            check("dump_queue_nonempty", 64'(exp_q.size() != 0), 64'h1);
            if (exp_q.size() != 0) begin
                check("dump_idx", 64'(dbg_idx), 64'(exp_q[0].idx));
                check("dump_data", 64'(dbg_data), 64'(exp_q[0].data));
                if (dbg_ready && dbg_valid) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
            end
            cyc++;
            tick();
        end
        w_en = 1'b0;
        dbg_ready = 1'b0;
        check("dump_handshakes", 64'(hs), 64'(NREGS - 1));
        check("dump_stall5_seen", 64'(phase), 64'h2);
        check("dump_queue_drained", 64'(exp_q.size()), 64'h0);
        @(negedge clk);
        check("dump_end_valid", 64'(dbg_valid), 64'h0);
        check("dump_end_active", 64'(dbg_active), 64'h0);

        // Reset mid-dump
        tick();
        dbg_req = 1'b1; dbg_ready = 1'b1;
        tick();
        dbg_req = 1'b0;
        cyc = 0;
        while (dbg_idx != 5'd10 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("abort_reach_idx10", 64'(dbg_idx), 64'd10);
        rst = 1'b1;
        #1;
        check("abort_valid_async", 64'(dbg_valid), 64'h0);
        check("abort_idx_async", 64'(dbg_idx), 64'h0);
        dbg_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("abort_idle_valid", 64'(dbg_valid), 64'h0);
        tick();
        dbg_req = 1'b1;
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        check("restart_valid", 64'(dbg_valid), 64'h1);
        check("restart_idx", 64'(dbg_idx), 64'h1);
        check("restart_data", 64'(dbg_data), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the RISC-V core, with a per-register pending-write scoreboard and a handshaked debug dump port. It replaces the fixed 32×32 two-port register file. The decode/issue stage reads it, writeback writes it, and the debug/trace unit streams the architectural state out through a valid/ready port instead of a flat wide bus.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers, a power of two ≥ 4. Register 0 is hardwired zero.
- NRD, 2: number of combinational read ports.
- AW, $clog2(NREGS): register index width. Derived; not to be overridden.

- clk  in  1  single core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- r_sel  in  NRD*AW  read indices; port k uses bits [k*AW +: AW].
- r_data  out  NRD*XLEN  read data, combinational from r_sel.
- r_busy  out  NRD  scoreboard bit of the register selected on each read port.
- w_en  in  1  writeback enable.
- w_sel  in  AW  writeback register index.
- w_data  in  XLEN  writeback data.
- sb_set  in  1  issue of an instruction that will write sb_sel; marks the register pending.
- sb_sel  in  AW  register to mark pending.
- sb_flush  in  1  clears all pending bits (pipeline flush).
- dbg_req  in  1  start a dump of registers 1..NREGS-1.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  consumer accepts a beat.
- dbg_idx  out  AW  index of the current beat.
- dbg_data  out  XLEN  value of the current beat.
- dbg_active  out  1  dump in progress.

## Operation
- Storage is NREGS × XLEN. Register 0 always reads 0 and is never stored, marked busy or dumped.
- Write: on a rising edge with w_en=1 and w_sel≠0, reg[w_sel] ← w_data, and busy[w_sel] clears.
- Scoreboard: on a rising edge with sb_set=1 and sb_sel≠0, busy[sb_sel] is set.
  - If sb_set and w_en target the same register in one cycle, set wins: the register ends busy and the data is written.
  - sb_flush clears every busy bit and takes priority over sb_set in the same cycle.
- Dump FSM has two states:
  - IDLE: dbg_valid=0, dbg_active=0. dbg_req=1 at an edge moves to BEAT with idx=1, and dbg_data is captured from reg[1].
  - BEAT: dbg_valid=1, dbg_active=1.
    - If dbg_ready=1 at an edge and idx<NREGS-1: idx increments and dbg_data is captured from reg[idx+1].
    - If dbg_ready=1 at an edge and idx=NREGS-1: the FSM returns to IDLE.
    - dbg_req is ignored while in BEAT.
- dbg_data is registered. While dbg_valid=1 and dbg_ready=0, dbg_idx and dbg_data hold stable even if the register is rewritten.
- The capture for the next beat samples storage after any same-edge write to that register. The written value is what gets dumped.

## Timing
- Reset: all registers 0, all busy bits 0, FSM IDLE, dbg_valid=0, dbg_active=0, dbg_idx=0, dbg_data=0.
- Reset mid-dump aborts the dump immediately. No further beats are produced.
- Read latency: combinational, zero cycles. A write becomes visible on the cycle after its edge, unless bypass is enabled (see Configuration).
- Dump:
  - First beat is valid one cycle after dbg_req is sampled.
  - Minimum dump length is NREGS-1 cycles with dbg_ready held high.
  - dbg_valid drops in the cycle after the final handshake.

## Configuration
- REGFILE_BYPASS_EN defined: when w_en=1, w_sel≠0 and r_sel[k]=w_sel, then:
  - r_data[k] = w_data, in the same cycle;
  - r_busy[k] = 0, unless sb_set targets the same register that cycle.
- REGFILE_BYPASS_EN undefined: reads return stored contents and the stored busy bit only. The written value and cleared busy bit appear the next cycle.
- Bypass never applies to register 0.

## Structure
- Shared package regfile_pkg holds:
  - default XLEN and NREGS constants;
  - the dump FSM state enum (DBG_IDLE, DBG_BEAT);
  - helper localparam for the register-0 index.
- One sub-module, regfile_scoreboard, holds the NREGS busy bits with set/clear/flush priority and the NRD lookup ports.
- Storage, read/bypass muxing and the dump FSM stay in regfile_mp.

## Test plan
- Reset then read: assert rst, deassert, read x5 and x31 → 0; r_busy=0; dbg_valid=0.
- Write/read: write x7=0xDEADBEEF and read x7 in the same cycle → 0xDEADBEEF with bypass, old value 0 without. The next cycle always returns 0xDEADBEEF. Writing x0=0x1234 → x0 still reads 0.
- Scoreboard:
  - sb_set x3 → r_busy on x3 next cycle.
  - w_en x3 plus sb_set x3 in the same cycle → stays busy.
  - w_en x3 alone → clears.
  - sb_set x4 plus sb_flush → x4 not busy.
- Dump with backpressure:
  - Preload xi=i*0x11 and pulse dbg_req.
  - Toggle dbg_ready randomly → beats idx 1..31 in order, data i*0x11, each held stable while stalled.
  - Exactly 31 handshakes, then dbg_valid=0.
- Write during a stalled beat: stall on idx=5 and write x5=0xAA → dbg_data stays 0x55. Write x6=0xBB while stalled on idx 5 → the next beat shows 0xBB.
- Reset mid-dump: assert rst at idx=10 → dbg_valid=0 asynchronously. After release the FSM is IDLE, and a new dbg_req restarts at idx=1.
